hilo_unit: RTL and testbench
============================

# hilo_unit

Multi-cycle sequencer and HI/LO result register bank for the multiply/divide path. It accepts a mult/div issue from EX, latches the operands, and holds them stable for the combinational multiply/divide unit for a fixed per-operation latency. It then captures the unit's 64-bit result into HI/LO. It also serves mfhi/mflo/mthi/mtlo and stalls the pipeline on any HI/LO hazard while an operation is in flight.

## Interface
Parameters:
- MULT_LAT, 4, cycles a multiply occupies the unit (≥1)
- DIV_LAT, 32, cycles a divide occupies the unit (≥1)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- mult_ex  in  1  issue multiply (qualified by !stall_md)
- div_ex  in  1  issue divide (qualified by !stall_md)
- sourceA_ex  in  32  operand A at issue
- sourceB_ex  in  32  operand B at issue
- flush_md  in  1  abort in-flight operation
- mfhi_ex  in  1  read HI
- mflo_ex  in  1  read LO
- mthi_ex  in  1  write HI
- mtlo_ex  in  1  write LO
- wdata_ex  in  32  mthi/mtlo data
- res64  in  64  result from multiply/divide unit ({HI,LO})
- md_a  out  32  latched operand A to multiply/divide unit
- md_b  out  32  latched operand B to multiply/divide unit
- md_mult  out  1  multiply select to multiply/divide unit
- md_div  out  1  divide select to multiply/divide unit
- rdata_ex  out  32  HI (mfhi) or LO (mflo), else 0
- stall_md  out  1  pipeline stall request
- busy  out  1  operation in flight
- hi  out  32  HI register
- lo  out  32  LO register

## Operation
- States: IDLE, BUSY. Down-counter cnt, 6 bits minimum, sized by max(MULT_LAT, DIV_LAT).
- Issue: the issue is accepted in IDLE when exactly one of mult_ex/div_ex is high.
  - On accept, latch md_a/md_b from sourceA_ex/sourceB_ex.
  - Set md_mult/md_div per the issuing op.
  - Load cnt = LAT-1 and go to BUSY.
- mult_ex and div_ex both high: illegal. No issue, no state change.
- BUSY: md_* hold. cnt decrements each cycle. When cnt==0:
  - hi ← res64[63:32], lo ← res64[31:0].
  - Clear md_mult/md_div.
  - Go to IDLE.
- res64 is captured verbatim. Divide-by-zero results are not trapped.
- stall_md (combinational) = busy & (mult_ex | div_ex | mfhi_ex | mflo_ex | mthi_ex | mtlo_ex). It stays high in the completion cycle.
- mthi/mtlo in IDLE with no stall: write wdata_ex at the edge. mthi and mtlo in the same cycle write both registers.
- rdata_ex (combinational): hi if mfhi_ex, else lo if mflo_ex, else 0. mfhi takes priority if both are high.
- mfhi/mflo in the same cycle as mthi/mtlo return the old value.
- flush_md:
  - In BUSY: go to IDLE, cnt←0, md_mult/md_div←0, HI/LO unchanged.
  - flush_md beats completion if coincident.
  - In IDLE: blocks any issue that cycle.
- Reset, in any state, including mid-operation:
  - state=IDLE, cnt=0.
  - hi=lo=0, md_a=md_b=0, md_mult=md_div=0.
  - busy=0, stall_md=0.

## Timing
- Issue accepted at edge T. BUSY spans cycles T+1 … T+LAT.
- Capture occurs at the edge ending cycle T+LAT. busy is low from cycle T+LAT+1.
- mfhi/mflo stalled in BUSY is released in cycle T+LAT+1 and returns the new value that cycle.
- md_a/md_b/md_mult/md_div are registered. They are valid from cycle T+1 and stable through T+LAT, giving the combinational unit LAT cycles of settling.
- Back-to-back issue:
  - A second issue held by stall is accepted at the end of T+LAT+1.
  - There is one IDLE cycle minimum between ops.
- No output depends combinationally on res64.

## Structure
- Shared package md_pkg holds:
  - typedef enum logic {MD_IDLE, MD_BUSY} md_state_t
  - MD_MULT_LAT_DEFAULT and MD_DIV_LAT_DEFAULT constants
- A single module; no sub-module is needed.
- The multiply/divide unit is instantiated alongside at the datapath top, driven by md_a/md_b/md_mult/md_div, with its res64 returned here.

## Test plan
- Reset then multiply: mult_ex with sourceA_ex=6, sourceB_ex=7, MULT_LAT=4 → busy high 4 cycles, then hi=0, lo=42.
- Divide: div_ex with 100/7, DIV_LAT=32 → busy high 32 cycles, then hi=2, lo=14.
- Read hazard: mfhi_ex held from T+1 after 100/7 → stall_md high through T+32; in T+33 stall_md=0 and rdata_ex=2.
- Move then read:
  - mthi 0xDEADBEEF in IDLE → mfhi next cycle returns 0xDEADBEEF.
  - Same-cycle mthi+mfhi returns the old HI.
- Flush/reset mid-operation:
  - flush_md at cnt==3 with prior hi=5, lo=9 → IDLE next cycle, hi=5, lo=9, md_mult=0.
  - reset mid-BUSY → all outputs zero.
- Issue while busy and illegal issue:
  - mult_ex during BUSY → stall_md=1 and md_a unchanged; accepted the cycle after completion.
  - mult_ex=div_ex=1 in IDLE → no state change.

Source files
------------

// File: rtl/md_pkg.sv
// Shared types and default latencies for the multiply/divide sequencer.
package md_pkg;

   typedef enum logic {MD_IDLE, MD_BUSY} md_state_t;

   localparam int MD_MULT_LAT_DEFAULT = 4;
   localparam int MD_DIV_LAT_DEFAULT  = 32;

   // Counter width: enough for the longest latency, never below 6 bits.
   function automatic int md_cnt_width(input int max_lat);
      int w;
      w = $clog2(max_lat);
      return (w < 6) ? 6 : w;
   endfunction

endpackage

// File: rtl/hilo_unit.sv
// HI/LO bank plus mult/div sequencer: latches operands, waits MULT_LAT/DIV_LAT cycles, captures res64.
// stall_md holds EX off any HI/LO access or new issue while an operation is in flight.
module hilo_unit
   import md_pkg::*;
#(
   parameter int MULT_LAT = MD_MULT_LAT_DEFAULT,
   parameter int DIV_LAT  = MD_DIV_LAT_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mult_ex,
   input  logic        div_ex,
   input  logic [31:0] sourceA_ex,
   input  logic [31:0] sourceB_ex,
   input  logic        flush_md,
   input  logic        mfhi_ex,
   input  logic        mflo_ex,
   input  logic        mthi_ex,
   input  logic        mtlo_ex,
   input  logic [31:0] wdata_ex,
   input  logic [63:0] res64,
   output logic [31:0] md_a,
   output logic [31:0] md_b,
   output logic        md_mult,
   output logic        md_div,
   output logic [31:0] rdata_ex,
   output logic        stall_md,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
   localparam int CW      = md_cnt_width(MAX_LAT);
   localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_LAT - 1);
   localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_LAT - 1);

   md_state_t     state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0]   md_a_q, md_a_d, md_b_q, md_b_d;
   logic          md_mult_q, md_mult_d, md_div_q, md_div_d;
   logic [31:0]   hi_q, hi_d, lo_q, lo_d;
   logic          issue_ok, move_ok;

   assign busy     = (state_q == MD_BUSY);
   assign stall_md = busy & (mult_ex | div_ex | mfhi_ex | mflo_ex | mthi_ex | mtlo_ex);
   assign issue_ok = (state_q == MD_IDLE) & (mult_ex ^ div_ex) & ~flush_md;
   assign move_ok  = (state_q == MD_IDLE) & ~stall_md;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      md_a_d    = md_a_q;
      md_b_d    = md_b_q;
      md_mult_d = md_mult_q;
      md_div_d  = md_div_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      case (state_q)
         MD_IDLE: begin
            if (issue_ok) begin
               state_d   = MD_BUSY;
               md_a_d    = sourceA_ex;
               md_b_d    = sourceB_ex;
               md_mult_d = mult_ex;
               md_div_d  = div_ex;
               cnt_d     = mult_ex ? MULT_LOAD : DIV_LOAD;
            end
         end
         MD_BUSY: begin
            // A flush coinciding with the final cycle discards the result.
            if (flush_md) begin
               state_d   = MD_IDLE;
               cnt_d     = '0;
               md_mult_d = 1'b0;
               md_div_d  = 1'b0;
            end else if (cnt_q == '0) begin
               state_d   = MD_IDLE;
               hi_d      = res64[63:32];
               lo_d      = res64[31:0];
               md_mult_d = 1'b0;
               md_div_d  = 1'b0;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: state_d = MD_IDLE;
      endcase
      if (move_ok && mthi_ex) hi_d = wdata_ex;
      if (move_ok && mtlo_ex) lo_d = wdata_ex;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= MD_IDLE;
         cnt_q     <= '0;
         md_a_q    <= '0;
         md_b_q    <= '0;
         md_mult_q <= 1'b0;
         md_div_q  <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         md_a_q    <= md_a_d;
         md_b_q    <= md_b_d;
         md_mult_q <= md_mult_d;
         md_div_q  <= md_div_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
      end
   end

   // Reads see the pre-edge register, so a same-cycle mthi/mtlo returns the old value.
   assign rdata_ex = mfhi_ex ? hi_q : (mflo_ex ? lo_q : 32'd0);

   assign md_a    = md_a_q;
   assign md_b    = md_b_q;
   assign md_mult = md_mult_q;
   assign md_div  = md_div_q;
   assign hi      = hi_q;
   assign lo      = lo_q;

endmodule

// File: tb/tb_hilo_unit.sv
// Bench for hilo_unit: behavioural mult/div unit on md_*, expected HI/LO results queued at issue.
module tb_hilo_unit;

   localparam int MULT_LAT = 4;
   localparam int DIV_LAT  = 32;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        mult_ex = 1'b0, div_ex = 1'b0, flush_md = 1'b0;
   logic        mfhi_ex = 1'b0, mflo_ex = 1'b0, mthi_ex = 1'b0, mtlo_ex = 1'b0;
   logic [31:0] sourceA_ex = '0, sourceB_ex = '0, wdata_ex = '0;
   logic [63:0] res64;
   logic [31:0] md_a, md_b, rdata_ex, hi, lo;
   logic        md_mult, md_div, stall_md, busy;

   int tests_run = 0;
   int tests_failed = 0;
   logic [63:0] sb[$];

   always #5 clk = ~clk;

   hilo_unit #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
      .clk(clk), .reset(reset), .mult_ex(mult_ex), .div_ex(div_ex),
      .sourceA_ex(sourceA_ex), .sourceB_ex(sourceB_ex), .flush_md(flush_md),
      .mfhi_ex(mfhi_ex), .mflo_ex(mflo_ex), .mthi_ex(mthi_ex), .mtlo_ex(mtlo_ex),
      .wdata_ex(wdata_ex), .res64(res64), .md_a(md_a), .md_b(md_b),
      .md_mult(md_mult), .md_div(md_div), .rdata_ex(rdata_ex), .stall_md(stall_md),
      .busy(busy), .hi(hi), .lo(lo)
   );

   // Stand-in combinational multiply/divide unit; a marker value when unselected.
   always_comb begin
      res64 = 64'hBAD0_BAD0_BAD0_BAD0;
      if (md_mult)
         res64 = {32'd0, md_a} * {32'd0, md_b};
      else if (md_div)
         res64 = (md_b == 32'd0) ? 64'hFFFF_FFFF_FFFF_FFFF : {md_a % md_b, md_a / md_b};
   end

   function automatic logic [63:0] md_model(input bit is_mult, input logic [31:0] a, input logic [31:0] b);
      if (is_mult) return {32'd0, a} * {32'd0, b};
      return {a % b, a / b};
   endfunction

   task automatic issue(input bit is_mult, input logic [31:0] a, input logic [31:0] b, input bit expect_result);
      @(negedge clk);
      mult_ex = is_mult; div_ex = ~is_mult; sourceA_ex = a; sourceB_ex = b;
      if (expect_result) sb.push_back(md_model(is_mult, a, b));
      @(negedge clk);
      mult_ex = 1'b0; div_ex = 1'b0; sourceA_ex = '0; sourceB_ex = '0;
   endtask

   // Counts busy cycles from the current one; a hang shows up as a wrong count.
   task automatic wait_done(output int n);
      n = 0;
      while (busy === 1'b1 && n < 200) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      mfhi_ex = 1'b1; #1;
      tests_run++;
      if ({hi, lo, md_a, md_b} !== 128'd0) begin
         tests_failed++; $display("FAIL reset_regs: got hi=%h lo=%h a=%h b=%h, want all 0", hi, lo, md_a, md_b);
      end
      tests_run++;
      if ({md_mult, md_div, busy, stall_md, rdata_ex} !== 36'd0) begin
         tests_failed++; $display("FAIL reset_ctrl: got mult=%b div=%b busy=%b stall=%b rdata=%h, want 0", md_mult, md_div, busy, stall_md, rdata_ex);
      end
      mfhi_ex = 1'b0;
      reset = 1'b0;
   endtask

   task automatic test_mult();
      int n;
      logic [63:0] exp;
      issue(1'b1, 32'd6, 32'd7, 1'b1);
      tests_run++;
      if ({md_a, md_b, md_mult, md_div} !== {32'd6, 32'd7, 1'b1, 1'b0}) begin
         tests_failed++; $display("FAIL mult_operands: got a=%0d b=%0d mult=%b div=%b, want 6 7 1 0", md_a, md_b, md_mult, md_div);
      end
      wait_done(n);
      tests_run++;
      if (n !== MULT_LAT) begin
         tests_failed++; $display("FAIL mult_latency: got %0d busy cycles, want %0d", n, MULT_LAT);
      end
      exp = sb.pop_front();
      tests_run++;
      if ({hi, lo} !== exp) begin
         tests_failed++; $display("FAIL mult_result: got %h_%h, want %h", hi, lo, exp);
      end
   endtask

   task automatic test_div();
      int n;
      logic [63:0] exp;
      issue(1'b0, 32'd100, 32'd7, 1'b1);
      tests_run++;
      if ({md_mult, md_div} !== 2'b01) begin
         tests_failed++; $display("FAIL div_select: got mult=%b div=%b, want 0 1", md_mult, md_div);
      end
      wait_done(n);
      tests_run++;
      if (n !== DIV_LAT) begin
         tests_failed++; $display("FAIL div_latency: got %0d busy cycles, want %0d", n, DIV_LAT);
      end
      exp = sb.pop_front();
      tests_run++;
      if ({hi, lo} !== exp) begin
         tests_failed++; $display("FAIL div_result: got %h_%h, want %h", hi, lo, exp);
      end
   endtask

   task automatic test_read_hazard();
      int n;
      logic [63:0] exp;
      @(negedge clk);
      div_ex = 1'b1; sourceA_ex = 32'd100; sourceB_ex = 32'd7;
      sb.push_back(md_model(1'b0, 32'd100, 32'd7));
      @(negedge clk);
      div_ex = 1'b0; mfhi_ex = 1'b1; #1;
      n = 0;
      while (stall_md === 1'b1 && n < 200) begin
         n++;
         @(negedge clk); #1;
      end
      tests_run++;
      if (n !== DIV_LAT) begin
         tests_failed++; $display("FAIL hazard_stall_len: got %0d stall cycles, want %0d", n, DIV_LAT);
      end
      exp = sb.pop_front();
      tests_run++;
      if ({busy, rdata_ex} !== {1'b0, exp[63:32]}) begin
         tests_failed++; $display("FAIL hazard_release_read: got busy=%b rdata=%0d, want 0 %0d", busy, rdata_ex, exp[63:32]);
      end
      mfhi_ex = 1'b0;
   endtask

   task automatic test_move();
      logic [31:0] old_hi;
      old_hi = 32'd2;
      @(negedge clk);
      mthi_ex = 1'b1; wdata_ex = 32'hDEADBEEF; mfhi_ex = 1'b1; #1;
      tests_run++;
      if (rdata_ex !== old_hi) begin
         tests_failed++; $display("FAIL move_same_cycle_old: got %h, want %h", rdata_ex, old_hi);
      end
      @(negedge clk);
      mthi_ex = 1'b0; mflo_ex = 1'b1; #1;
      tests_run++;
      if (rdata_ex !== 32'hDEADBEEF) begin
         tests_failed++; $display("FAIL move_mfhi_priority: got %h, want deadbeef", rdata_ex);
      end
      mfhi_ex = 1'b0; mflo_ex = 1'b0;
      mthi_ex = 1'b1; mtlo_ex = 1'b1; wdata_ex = 32'h1234_5678;
      @(negedge clk);
      mthi_ex = 1'b0; mtlo_ex = 1'b0; mflo_ex = 1'b1; #1;
      tests_run++;
      if ({hi, lo, rdata_ex} !== {32'h1234_5678, 32'h1234_5678, 32'h1234_5678}) begin
         tests_failed++; $display("FAIL move_both: got hi=%h lo=%h rdata=%h, want 12345678 x3", hi, lo, rdata_ex);
      end
      mflo_ex = 1'b0; #1;
      tests_run++;
      if (rdata_ex !== 32'd0) begin
         tests_failed++; $display("FAIL move_no_read: got %h, want 0", rdata_ex);
      end
   endtask

   task automatic test_flush();
      @(negedge clk);
      mthi_ex = 1'b1; wdata_ex = 32'd5;
      @(negedge clk);
      mthi_ex = 1'b0; mtlo_ex = 1'b1; wdata_ex = 32'd9;
      @(negedge clk);
      mtlo_ex = 1'b0;
      mult_ex = 1'b1; sourceA_ex = 32'd3; sourceB_ex = 32'd5;
      @(negedge clk);
      mult_ex = 1'b0; flush_md = 1'b1;
      @(negedge clk);
      flush_md = 1'b0;
      tests_run++;
      if ({busy, md_mult, hi, lo} !== {1'b0, 1'b0, 32'd5, 32'd9}) begin
         tests_failed++; $display("FAIL flush_busy: got busy=%b mult=%b hi=%0d lo=%0d, want 0 0 5 9", busy, md_mult, hi, lo);
      end
      repeat (MULT_LAT) @(negedge clk);
      tests_run++;
      if ({hi, lo} !== {32'd5, 32'd9}) begin
         tests_failed++; $display("FAIL flush_no_late_capture: got hi=%0d lo=%0d, want 5 9", hi, lo);
      end
      mult_ex = 1'b1; flush_md = 1'b1; sourceA_ex = 32'd8;
      @(negedge clk);
      mult_ex = 1'b0; flush_md = 1'b0;
      tests_run++;
      if ({busy, md_a} !== {1'b0, 32'd3}) begin
         tests_failed++; $display("FAIL flush_idle_blocks: got busy=%b md_a=%0d, want 0 3", busy, md_a);
      end
   endtask

   task automatic test_back_to_back();
      int n;
      bit moved;
      logic [63:0] exp;
      @(negedge clk);
      mult_ex = 1'b1; sourceA_ex = 32'd1000; sourceB_ex = 32'd3000;
      sb.push_back(md_model(1'b1, 32'd1000, 32'd3000));
      @(negedge clk);
      sourceA_ex = 32'd11; sourceB_ex = 32'd13; #1;
      n = 0; moved = 1'b0;
      while (stall_md === 1'b1 && n < 200) begin
         if (md_a !== 32'd1000) moved = 1'b1;
         n++;
         @(negedge clk); #1;
      end
      tests_run++;
      if (n !== MULT_LAT || moved) begin
         tests_failed++; $display("FAIL b2b_stall: got %0d stall cycles moved=%b, want %0d 0", n, moved, MULT_LAT);
      end
      exp = sb.pop_front();
      tests_run++;
      if ({busy, hi, lo} !== {1'b0, exp}) begin
         tests_failed++; $display("FAIL b2b_first_result: got busy=%b %h_%h, want 0 %h", busy, hi, lo, exp);
      end
      sb.push_back(md_model(1'b1, 32'd11, 32'd13));
      @(negedge clk);
      mult_ex = 1'b0;
      tests_run++;
      if ({busy, md_a, md_b} !== {1'b1, 32'd11, 32'd13}) begin
         tests_failed++; $display("FAIL b2b_second_issue: got busy=%b a=%0d b=%0d, want 1 11 13", busy, md_a, md_b);
      end
      wait_done(n);
      exp = sb.pop_front();
      tests_run++;
      if (n !== MULT_LAT || {hi, lo} !== exp) begin
         tests_failed++; $display("FAIL b2b_second_result: got %0d cycles %h_%h, want %0d %h", n, hi, lo, MULT_LAT, exp);
      end
   endtask

   task automatic test_illegal();
      @(negedge clk);
      mult_ex = 1'b1; div_ex = 1'b1; sourceA_ex = 32'd77;
      @(negedge clk);
      mult_ex = 1'b0; div_ex = 1'b0;
      tests_run++;
      if ({busy, md_mult, md_div, md_a} !== {3'b000, 32'd11}) begin
         tests_failed++; $display("FAIL illegal_issue: got busy=%b mult=%b div=%b a=%0d, want 0 0 0 11", busy, md_mult, md_div, md_a);
      end
   endtask

   task automatic test_reset_mid();
      issue(1'b0, 32'd50, 32'd3, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      mult_ex = 1'b1; mfhi_ex = 1'b1; #1;
      tests_run++;
      if ({hi, lo, md_a, md_b, md_mult, md_div, busy, stall_md, rdata_ex} !== 164'd0) begin
         tests_failed++; $display("FAIL reset_mid_op: got hi=%h lo=%h a=%h b=%h mult=%b div=%b busy=%b stall=%b rdata=%h, want all 0",
                                  hi, lo, md_a, md_b, md_mult, md_div, busy, stall_md, rdata_ex);
      end
      mult_ex = 1'b0; mfhi_ex = 1'b0; reset = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_mult();
      test_div();
      test_read_hazard();
      test_move();
      test_flush();
      test_back_to_back();
      test_illegal();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
